// File: rtl/urv_trap_sequencer_pkg.sv
// Shared definitions for the uRV trap sequencer: cause codes, interrupt bit
// indices, FSM state encodings and the priority-encoder result payload.
package urv_trap_sequencer_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned HOLDOFF_W  = 8;
  localparam int unsigned STATE_W    = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT      = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_INVALID         = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_UNALIGNED_LOAD  = 4'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_UNALIGNED_STORE = 4'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER           = 4'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ             = 4'd11;

  // Bit positions inside mie/mip
  localparam int unsigned EXCEPT_TIMER = 7;
  localparam int unsigned EXCEPT_IRQ   = 11;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ENTER   = 3'd1;
  localparam logic [STATE_W-1:0] ST_FLUSH   = 3'd2;
  localparam logic [STATE_W-1:0] ST_HANDLER = 3'd3;
  localparam logic [STATE_W-1:0] ST_RETURN  = 3'd4;

  typedef struct packed {
    logic               valid;
    logic               is_irq;
    logic [CAUSE_W-1:0] cause;
  } trap_req_t;

endpackage

// File: rtl/urv_trap_prio.sv
// Fixed-priority trap selector: synchronous flags first, then timer, then
// external interrupt. Purely combinational.
module urv_trap_prio
  import urv_trap_sequencer_pkg::*;
(
  input  logic      i_breakpoint,
  input  logic      i_invalid,
  input  logic      i_unaligned_load,
  input  logic      i_unaligned_store,
  input  logic      i_timer,
  input  logic      i_irq,
  output trap_req_t o_req_c
);

  always_comb begin
    o_req_c = '0;
    if (i_breakpoint) begin
      o_req_c.valid = 1'b1;
      o_req_c.cause = CAUSE_BREAKPOINT;
    end else if (i_invalid) begin
      o_req_c.valid = 1'b1;
      o_req_c.cause = CAUSE_INVALID;
    end else if (i_unaligned_load) begin
      o_req_c.valid = 1'b1;
      o_req_c.cause = CAUSE_UNALIGNED_LOAD;
    end else if (i_unaligned_store) begin
      o_req_c.valid = 1'b1;
      o_req_c.cause = CAUSE_UNALIGNED_STORE;
    end else if (i_timer) begin
      o_req_c.valid  = 1'b1;
      o_req_c.is_irq = 1'b1;
      o_req_c.cause  = CAUSE_TIMER;
    end else if (i_irq) begin
      o_req_c.valid  = 1'b1;
      o_req_c.is_irq = 1'b1;
      o_req_c.cause  = CAUSE_IRQ;
    end
  end

endmodule

// File: rtl/urv_trap_sequencer.sv
// Trap entry/exit controller for the uRV execute stage: prioritises traps,
// drives the CSR unit's exception strobe, redirects fetch and enforces an
// interrupt hold-off after every mret.
module urv_trap_sequencer
  import urv_trap_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR    = 32'h0000_0008,
  parameter int unsigned     HOLDOFF_CYCLES = 4
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              x_valid_i,
  input  logic              x_stall_i,
  input  logic [XLEN-1:0]   x_pc_i,
  input  logic              x_exc_breakpoint_i,
  input  logic              x_exc_invalid_insn_i,
  input  logic              x_exc_unaligned_load_i,
  input  logic              x_exc_unaligned_store_i,
  input  logic              x_is_mret_i,
  input  logic              irq_i,
  input  logic              tick_i,
  input  logic              csr_ie_i,
  input  logic [XLEN-1:0]   csr_mie_i,
  input  logic [XLEN-1:0]   csr_mepc_i,
  output logic              trap_o,
  output logic [CAUSE_W-1:0] trap_cause_o,
  output logic              trap_is_irq_o,
  output logic [XLEN-1:0]   trap_pc_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              kill_o,
  output logic              busy_o,
  output logic [XLEN-1:0]   mip_o
);

  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_nxt;
  logic [HOLDOFF_W-1:0] r_holdoff;
  logic                 r_timer_pend;
  logic                 r_irq_pend;
  logic                 r_trap;
  logic                 r_redirect;
  logic                 r_kill;
  logic                 r_busy;
  logic [CAUSE_W-1:0]   r_cause;
  logic                 r_is_irq;
  logic [XLEN-1:0]      r_trap_pc;
  logic [XLEN-1:0]      r_redirect_pc;

  logic      w_accept;
  logic      w_quiet;
  logic      w_timer_elig;
  logic      w_irq_elig;
  logic      w_take;
  logic      w_ret;
  logic      w_timer_taken;
  trap_req_t w_req;
  logic [XLEN-1:0] w_mip;
  logic      w_unused_mie;

  assign w_accept     = x_valid_i && !x_stall_i;
  // Interrupts only in IDLE once the post-mret hold-off has drained
  assign w_quiet      = (r_state == ST_IDLE) && (r_holdoff == '0);
  assign w_timer_elig = w_quiet && csr_ie_i && csr_mie_i[EXCEPT_TIMER] && r_timer_pend;
  assign w_irq_elig   = w_quiet && csr_ie_i && csr_mie_i[EXCEPT_IRQ] && r_irq_pend;
  assign w_unused_mie = ^{csr_mie_i[31:12], csr_mie_i[10:8], csr_mie_i[6:0]};

  urv_trap_prio u_prio (
    .i_breakpoint      (x_exc_breakpoint_i),
    .i_invalid         (x_exc_invalid_insn_i),
    .i_unaligned_load  (x_exc_unaligned_load_i),
    .i_unaligned_store (x_exc_unaligned_store_i),
    .i_timer           (w_timer_elig),
    .i_irq             (w_irq_elig),
    .o_req_c           (w_req)
  );

  // Next-state logic; outside IDLE the eligible-irq inputs are already 0
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ret       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_req.valid) begin
          w_state_nxt = ST_ENTER;
          w_take      = 1'b1;
        end
      end
      ST_ENTER:  w_state_nxt = ST_FLUSH;
      ST_FLUSH:  w_state_nxt = ST_HANDLER;
      ST_HANDLER: begin
        if (w_accept && w_req.valid) begin
          w_state_nxt = ST_ENTER;
          w_take      = 1'b1;
        end else if (w_accept && x_is_mret_i) begin
          w_state_nxt = ST_RETURN;
          w_ret       = 1'b1;
        end
      end
      ST_RETURN: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_timer_taken = w_take && w_req.is_irq && (w_req.cause == CAUSE_TIMER);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Registered strobes, trap record and pending/hold-off bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trap        <= 1'b0;
      r_redirect    <= 1'b0;
      r_kill        <= 1'b0;
      r_busy        <= 1'b0;
      r_cause       <= '0;
      r_is_irq      <= 1'b0;
      r_trap_pc     <= '0;
      r_redirect_pc <= '0;
      r_timer_pend  <= 1'b0;
      r_irq_pend    <= 1'b0;
      r_holdoff     <= '0;
    end else begin
      r_trap     <= w_take;
      r_redirect <= w_take || w_ret;
      r_kill     <= (w_state_nxt == ST_ENTER) || (w_state_nxt == ST_FLUSH) ||
                    (w_state_nxt == ST_RETURN);
      r_busy     <= (w_state_nxt != ST_IDLE);
      if (w_take) begin
        r_cause       <= w_req.cause;
        r_is_irq      <= w_req.is_irq;
        r_trap_pc     <= x_pc_i;
        r_redirect_pc <= TRAP_VECTOR;
      end else if (w_ret) begin
        r_redirect_pc <= csr_mepc_i;
      end
      // A tick coinciding with the timer trap keeps the interrupt pending
      r_timer_pend <= tick_i || (r_timer_pend && !w_timer_taken);
      r_irq_pend   <= irq_i;
      if (r_state == ST_RETURN) begin
        r_holdoff <= HOLDOFF_W'(HOLDOFF_CYCLES);
      end else if ((r_state == ST_IDLE) && (r_holdoff != '0)) begin
        r_holdoff <= r_holdoff - HOLDOFF_W'(1);
      end
    end
  end

  always_comb begin
    w_mip               = '0;
    w_mip[EXCEPT_TIMER] = r_timer_pend;
    w_mip[EXCEPT_IRQ]   = r_irq_pend;
  end

  assign trap_o        = r_trap;
  assign trap_cause_o  = r_cause;
  assign trap_is_irq_o = r_is_irq;
  assign trap_pc_o     = r_trap_pc;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign kill_o        = r_kill;
  assign busy_o        = r_busy;
  assign mip_o         = w_mip;

endmodule
